// File: rtl/ysyx_23060072_regfile_mp_if.sv
// ysyx_23060072_regfile_mp_if: read, writeback, issue and clear signals of the multi-port register file
interface ysyx_23060072_regfile_mp_if #(
  parameter int XLEN   = 32,
  parameter int AW     = 4,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  logic [NUM_RD*AW-1:0]   rd_addr_i;
  logic [NUM_RD*XLEN-1:0] rd_data_o;
  logic [NUM_RD-1:0]      rd_busy_o;
  logic [NUM_WR-1:0]      wr_en_i;
  logic [NUM_WR*AW-1:0]   wr_addr_i;
  logic [NUM_WR*XLEN-1:0] wr_data_i;
  logic                   iss_valid_i;
  logic [AW-1:0]          iss_rd_i;
  logic                   iss_ready_o;
  logic                   clr_req_i;
  logic                   clr_busy_o;
  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_valid_i, iss_rd_i, clr_req_i,
    input  rd_data_o, rd_busy_o, iss_ready_o, clr_busy_o
  );
  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_valid_i, iss_rd_i, clr_req_i,
    output rd_data_o, rd_busy_o, iss_ready_o, clr_busy_o
  );
endinterface

// File: rtl/ysyx_23060072_regfile_mp.sv
// ysyx_23060072_regfile_mp: multi-port register file with busy scoreboard and sequential clear engine
// Define YSYX_23060072_RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module ysyx_23060072_regfile_mp #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input logic clk,
  input logic rst_n,
  ysyx_23060072_regfile_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef YSYX_23060072_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] regs [DEPTH];
  logic [XLEN-1:0] wr_val [DEPTH];
  logic [DEPTH-1:0] busy, wr_hit, set_mask;
  logic [AW-1:0] cnt;
  logic idle, fire;
  assign idle = state == IDLE;
  // later ports overwrite earlier ones, so the highest index wins on a collision
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < DEPTH; r++) wr_val[r] = '0;
    for (int p = 0; p < NUM_WR; p++)
      if (bus.wr_en_i[p]) begin
        wr_hit[bus.wr_addr_i[p*AW +: AW]] = 1'b1;
        wr_val[bus.wr_addr_i[p*AW +: AW]] = bus.wr_data_i[p*XLEN +: XLEN];
      end
  end
  assign bus.iss_ready_o = idle && (bus.iss_rd_i == '0 || !busy[bus.iss_rd_i] || wr_hit[bus.iss_rd_i]);
  assign bus.clr_busy_o = !idle;
  assign fire = bus.iss_valid_i && bus.iss_ready_o;
  assign set_mask = (fire && bus.iss_rd_i != '0) ? DEPTH'(1) << bus.iss_rd_i : '0;
  always_comb state_nx = idle ? (bus.clr_req_i ? CLEAR : IDLE) : (cnt == AW'(DEPTH - 1) ? IDLE : CLEAR);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      busy <= '0;
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      state <= state_nx;
      if (idle) begin
        for (int r = 1; r < DEPTH; r++) if (wr_hit[r]) regs[r] <= wr_val[r];
        busy <= bus.clr_req_i ? '0 : (busy & ~wr_hit) | set_mask;
        cnt <= bus.clr_req_i ? AW'(1) : '0;
      end else begin
        regs[cnt] <= '0;
        cnt <= cnt + AW'(1);
      end
    end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic hit;
    assign a = bus.rd_addr_i[k*AW +: AW];
    assign hit = BYP && idle && a != '0 && wr_hit[a];
    assign bus.rd_data_o[k*XLEN +: XLEN] = (a == '0) ? '0 : hit ? wr_val[a] : regs[a];
    assign bus.rd_busy_o[k] = busy[a] && !hit;
  end
endmodule
